// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector that tracks unretired register writers in a shift-register scoreboard.
// Define HZRD_FWD_EN to enable forwarding so that only a load-use match stalls.
module hazard_scoreboard #(
    parameter  int REG_AW     = 4,
    parameter  int NSRC       = 3,
    parameter  int PIPE_DEPTH = 2,
    parameter  int CNT_W      = 16,
    localparam int FSEL_W     = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     freeze,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic                     id_wb_en,
    input  logic                     id_mem_read,
    input  logic [REG_AW-1:0]        id_dest,
    input  logic [NSRC*REG_AW-1:0]   src_addr,
    input  logic [NSRC-1:0]          src_used,
    input  logic                     cnt_clr,
    output logic                     hazard,
    output logic [NSRC*FSEL_W-1:0]   fwd_sel,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Entry 0 is the instruction in EXE; higher indices are older.
    logic [PIPE_DEPTH-1:0] ent_valid;
    logic [PIPE_DEPTH-1:0] ent_wb_en;
    logic [REG_AW-1:0]     ent_dest [PIPE_DEPTH];

    logic [REG_AW-1:0]     src;
    logic                  hit;

`ifdef HZRD_FWD_EN
    // Only the EXE entry can cause a load-use stall, so only it keeps the load flag.
    logic                  ent0_mem_read;
    logic                  load_use;
`else
    logic                  any_match;
    logic                  unused_mem_read;
    assign unused_mem_read = id_mem_read;
`endif

    // NOTE: always_comb assigns every output a default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        hazard  = 1'b0;
        fwd_sel = '0;
        src     = '0;
        hit     = 1'b0;
`ifdef HZRD_FWD_EN
        load_use = 1'b0;
`else
        any_match = 1'b0;
`endif
        for (int i = 0; i < NSRC; i++) begin
            src = src_addr[i*REG_AW +: REG_AW];
            // Walk oldest to youngest so the youngest matching entry is the one that sticks.
            for (int e = PIPE_DEPTH - 1; e >= 0; e--) begin
                hit = src_used[i] & ent_valid[e] & ent_wb_en[e] & (ent_dest[e] == src);
`ifdef HZRD_FWD_EN
                if (hit) begin
                    if (e == 0 && ent0_mem_read)
                        load_use = 1'b1;
                    else
                        fwd_sel[i*FSEL_W +: FSEL_W] = FSEL_W'(e + 1);
                end
`else
                any_match = any_match | hit;
`endif
            end
        end
`ifdef HZRD_FWD_EN
        hazard = id_valid & load_use;
`else
        hazard = id_valid & any_match;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
        end else if (!freeze) begin
            for (int e = PIPE_DEPTH - 1; e > 0; e--)
                ent_valid[e] <= ent_valid[e-1];
            ent_valid[0] <= id_valid & ~hazard & ~flush;
        end
    end

    // NOTE: payload fields are not reset; they are qualified by ent_valid, which is.
    always_ff @(posedge clk) begin
        if (!freeze) begin
            for (int e = PIPE_DEPTH - 1; e > 0; e--) begin
                ent_wb_en[e] <= ent_wb_en[e-1];
                ent_dest[e]  <= ent_dest[e-1];
            end
            ent_wb_en[0] <= id_wb_en;
            ent_dest[0]  <= id_dest;
`ifdef HZRD_FWD_EN
            ent0_mem_read <= id_mem_read;
`endif
        end
    end

    // Software clear wins over both freeze and increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (cnt_clr)
            stall_cnt <= '0;
        else if (hazard && !freeze && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; expectations follow HZRD_FWD_EN when defined.
module tb_hazard_scoreboard;

`ifdef HZRD_FWD_EN
    localparam int LU  = 1;
    localparam bit FWD = 1'b1;
`else
    localparam int LU  = 2;
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze, flush, cnt_clr;
    logic        id_valid, id_wb_en, id_mem_read;
    logic [3:0]  id_dest;
    logic [11:0] src_addr;
    logic [2:0]  src_used;
    logic        hazard;
    logic [5:0]  fwd_sel;
    logic [15:0] stall_cnt;

    logic        s_valid, s_wb_en, s_mem_read;
    logic [3:0]  s_dest;
    logic [11:0] s_src_addr;
    logic [2:0]  s_src_used;
    logic        s_hazard;
    logic [11:0] s_fwd_sel;
    logic [15:0] s_stall_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .src_addr(src_addr), .src_used(src_used),
        .cnt_clr(cnt_clr), .hazard(hazard), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
    );

    // Deep instance so a continuous self-dependent stream stalls 15 of every 16 cycles.
    hazard_scoreboard #(.PIPE_DEPTH(15)) u_sat (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_valid(s_valid), .id_wb_en(s_wb_en), .id_mem_read(s_mem_read),
        .id_dest(s_dest), .src_addr(s_src_addr), .src_used(s_src_used),
        .cnt_clr(cnt_clr), .hazard(s_hazard), .fwd_sel(s_fwd_sel), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic issue(input logic v, input logic wb, input logic mr, input logic [3:0] d,
                         input logic [11:0] sa, input logic [2:0] su);
        id_valid    = v;
        id_wb_en    = wb;
        id_mem_read = mr;
        id_dest     = d;
        src_addr    = sa;
        src_used    = su;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 4'd0, 12'h0, 3'b000);
        s_valid = 1'b0; s_wb_en = 1'b0; s_mem_read = 1'b0; s_dest = 4'd0;
        s_src_addr = 12'h0; s_src_used = 3'b000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state with all sources in use.
        issue(1'b1, 1'b0, 1'b0, 4'd0, {4'd3, 4'd2, 4'd1}, 3'b111);
        settle;
        check("rst_hazard", hazard, 1'b0);
        check("rst_fwd", fwd_sel, 6'd0);
        check("rst_cnt", stall_cnt, 16'd0);
        tick;

        // Load R5, then read R5 on src0.
        issue(1'b1, 1'b1, 1'b1, 4'd5, 12'h0, 3'b000);
        tick;
        issue(1'b1, 1'b0, 1'b0, 4'd0, {4'd0, 4'd0, 4'd5}, 3'b001);
        settle;
        check("lu_hz_e0", hazard, 1'b1);
        check("lu_fwd_e0", fwd_sel, 6'd0);
        tick;
        settle;
        check("lu_hz_e1", hazard, !FWD);
        check("lu_fwd_e1", fwd_sel, FWD ? 6'd2 : 6'd0);
        tick;
        settle;
        check("lu_hz_done", hazard, 1'b0);
        exp_cnt = LU;
        check("lu_cnt", stall_cnt, exp_cnt);
        tick;

        // Use mask: R5 on unused src0 does not match; src1 alone does.
        issue(1'b1, 1'b1, 1'b1, 4'd5, 12'h0, 3'b000);
        tick;
        issue(1'b1, 1'b0, 1'b0, 4'd0, {4'd0, 4'd0, 4'd5}, 3'b110);
        settle;
        check("mask_off_hz", hazard, 1'b0);
        tick;
        issue(1'b1, 1'b0, 1'b0, 4'd0, {4'd0, 4'd5, 4'd9}, 3'b010);
        settle;
        check("mask_src1_hz", hazard, !FWD);
        check("mask_src1_fwd", fwd_sel, FWD ? 6'd8 : 6'd0);
        tick;
        exp_cnt = exp_cnt + (FWD ? 0 : 1);
        settle;
        check("mask_cnt", stall_cnt, exp_cnt);

        // R15 written by two ALU ops, read on src2: youngest entry wins.
        issue(1'b1, 1'b1, 1'b0, 4'd15, 12'h0, 3'b000);
        tick;
        tick;
        issue(1'b1, 1'b0, 1'b0, 4'd0, {4'd15, 4'd0, 4'd0}, 3'b100);
        settle;
        check("r15_hz", hazard, !FWD);
        check("r15_fwd", fwd_sel, FWD ? 6'd16 : 6'd0);
        id_valid = 1'b0;
        #1;
        check("r15_invalid_hz", hazard, 1'b0);
        tick;
        tick;

        // Freeze for three cycles during a load-use hazard.
        issue(1'b1, 1'b1, 1'b1, 4'd6, 12'h0, 3'b000);
        tick;
        issue(1'b1, 1'b0, 1'b0, 4'd0, {4'd0, 4'd0, 4'd6}, 3'b001);
        freeze = 1'b1;
        settle;
        check("frz_hz0", hazard, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick;
            settle;
            check("frz_hz", hazard, 1'b1);
            check("frz_cnt", stall_cnt, exp_cnt);
        end
        freeze = 1'b0;
        tick;
        settle;
        check("unfrz_hz", hazard, !FWD);
        tick;
        settle;
        check("unfrz_hz_done", hazard, 1'b0);
        exp_cnt = exp_cnt + LU;
        check("unfrz_cnt", stall_cnt, exp_cnt);

        // Flushed writer to R4 enters as a bubble.
        issue(1'b1, 1'b1, 1'b1, 4'd4, 12'h0, 3'b000);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        issue(1'b1, 1'b0, 1'b0, 4'd0, {4'd0, 4'd0, 4'd4}, 3'b001);
        settle;
        check("flush_hz_e0", hazard, 1'b0);
        tick;
        settle;
        check("flush_hz_e1", hazard, 1'b0);
        tick;

        // Counter clear in the middle of a stall.
        issue(1'b1, 1'b1, 1'b1, 4'd8, 12'h0, 3'b000);
        tick;
        issue(1'b1, 1'b0, 1'b0, 4'd0, {4'd0, 4'd0, 4'd8}, 3'b001);
        cnt_clr = 1'b1;
        settle;
        check("clr_hz", hazard, 1'b1);
        tick;
        cnt_clr = 1'b0;
        settle;
        check("clr_cnt", stall_cnt, 16'd0);
        tick;
        settle;
        check("clr_cnt_after", stall_cnt, LU - 1);
        tick;

        // Asynchronous reset in the middle of a stall.
        issue(1'b1, 1'b1, 1'b1, 4'd9, 12'h0, 3'b000);
        tick;
        issue(1'b1, 1'b0, 1'b0, 4'd0, {4'd0, 4'd0, 4'd9}, 3'b001);
        settle;
        check("arst_pre_hz", hazard, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_hz", hazard, 1'b0);
        check("arst_cnt", stall_cnt, 16'd0);
        rst_n = 1'b1;
        tick;
        settle;
        check("arst_post_hz", hazard, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 4'd0, 12'h0, 3'b000);

`ifndef HZRD_FWD_EN
        // Self-dependent writer stream on the deep instance drives the counter into saturation.
        tick;
        s_valid = 1'b1; s_wb_en = 1'b1; s_mem_read = 1'b1; s_dest = 4'd5;
        s_src_addr = {4'd0, 4'd0, 4'd5}; s_src_used = 3'b001;
        repeat (16) @(posedge clk);
        settle;
        check("sat_cnt_16", s_stall_cnt, 16'd15);
        repeat (70000) @(posedge clk);
        settle;
        check("sat_cnt_max", s_stall_cnt, 16'hFFFF);
        s_valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
